// File: rtl/ky32_pkg.sv
// Shared constants for the kythera32 data-memory path: RV32I width codes,
// MMIO register offsets and the default register-window base.
package ky32_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [3:0] MMIO_GPIO     = 4'h0;
    localparam logic [3:0] MMIO_CYCLE_LO = 4'h4;
    localparam logic [3:0] MMIO_CYCLE_HI = 4'h8;
    localparam logic [3:0] MMIO_FAULT    = 4'hC;

    localparam logic [31:0] MMIO_BASE_DEFAULT = 32'hFFFF_0000;

    // Word index inside the 16-byte window (addr[3:2]).
    typedef enum logic [1:0] {
        REG_GPIO     = MMIO_GPIO[3:2],
        REG_CYCLE_LO = MMIO_CYCLE_LO[3:2],
        REG_CYCLE_HI = MMIO_CYCLE_HI[3:2],
        REG_FAULT    = MMIO_FAULT[3:2]
    } mmio_reg_e;

endpackage

// File: rtl/ky32_lsu_align.sv
// Combinational lane logic for RV32I loads/stores: lane select, sign/zero
// extension, byte enables, store-data replication and width alignment check.
module ky32_lsu_align
    import ky32_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  byte_off,
    input  logic [31:0] load_word,
    input  logic [31:0] store_data,
    output logic [31:0] load_data,
    output logic [3:0]  byte_en,
    output logic [31:0] store_word,
    output logic        align_err
);

    logic [7:0]  lane_b_s;
    logic [15:0] lane_h_s;

    // Pick the addressed byte and halfword out of the source word.
    always_comb begin
        lane_b_s = load_word[7:0];
        case (byte_off)
            2'd0:    lane_b_s = load_word[7:0];
            2'd1:    lane_b_s = load_word[15:8];
            2'd2:    lane_b_s = load_word[23:16];
            2'd3:    lane_b_s = load_word[31:24];
            default: lane_b_s = load_word[7:0];
        endcase
        if (byte_off[1]) begin
            lane_h_s = load_word[31:16];
        end else begin
            lane_h_s = load_word[15:0];
        end
    end

    // Width decode: load extension, store lanes and the alignment rule.
    always_comb begin
        load_data  = 32'h0000_0000;
        byte_en    = 4'b0000;
        store_word = store_data;
        align_err  = 1'b1;
        case (funct3)
            F3_B, F3_BU: begin
                load_data  = (funct3 == F3_B) ? {{24{lane_b_s[7]}}, lane_b_s}
                                              : {24'h00_0000, lane_b_s};
                byte_en    = 4'b0001 << byte_off;
                store_word = {4{store_data[7:0]}};
                align_err  = 1'b0;
            end
            F3_H, F3_HU: begin
                load_data  = (funct3 == F3_H) ? {{16{lane_h_s[15]}}, lane_h_s}
                                              : {16'h0000, lane_h_s};
                byte_en    = byte_off[1] ? 4'b1100 : 4'b0011;
                store_word = {2{store_data[15:0]}};
                align_err  = byte_off[0];
            end
            F3_W: begin
                load_data  = load_word;
                byte_en    = 4'b1111;
                store_word = store_data;
                align_err  = (byte_off != 2'b00);
            end
            default: begin
                load_data  = 32'h0000_0000;
                byte_en    = 4'b0000;
                store_word = store_data;
                align_err  = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/ky32_dmem.sv
// Data-memory responder for the kythera32 core: word RAM with byte lanes plus
// a 16-byte MMIO window (GPIO, 64-bit cycle counter with HI snapshot, fault).
module ky32_dmem
    import ky32_pkg::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] MMIO_BASE   = MMIO_BASE_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        we,
    input  logic        re,
    input  logic [2:0]  funct3,
    output logic [31:0] rdata,
    output logic        misaligned,
    output logic        fault,
    output logic [31:0] gpio_out
);

    localparam int          AW        = $clog2(DEPTH_WORDS);
    localparam logic [32:0] RAM_BYTES = 33'(DEPTH_WORDS) << 2;

    logic [31:0] mem_r [DEPTH_WORDS];

    logic [63:0] cycle_cnt_r;
    logic [31:0] cycle_hi_snap_r;
    logic [31:0] fault_addr_r;
    logic [31:0] gpio_r;
    logic        fault_r;

    logic [AW-1:0] word_idx_s;
    logic          is_ram_s;
    logic          is_mmio_s;
    logic          align_err_s;
    logic          illegal_s;
    logic          legal_rd_s;
    logic          legal_wr_s;
    mmio_reg_e     mmio_sel_s;
    logic [31:0]   ram_word_s;
    logic [31:0]   mmio_word_s;
    logic [31:0]   src_word_s;
    logic [31:0]   load_ext_s;
    logic [31:0]   store_word_s;
    logic [3:0]    byte_en_s;

    assign word_idx_s = addr[AW+1:2];
    assign is_ram_s   = ({1'b0, addr} < RAM_BYTES);
    assign is_mmio_s  = (addr[31:4] == MMIO_BASE[31:4]);
    assign mmio_sel_s = mmio_reg_e'(addr[3:2]);
    assign ram_word_s = mem_r[word_idx_s];

    ky32_lsu_align u_align (
        .funct3     (funct3),
        .byte_off   (addr[1:0]),
        .load_word  (src_word_s),
        .store_data (wdata),
        .load_data  (load_ext_s),
        .byte_en    (byte_en_s),
        .store_word (store_word_s),
        .align_err  (align_err_s)
    );

    // Legality only matters while the core is actually accessing memory.
    always_comb begin
        illegal_s = 1'b0;
        if (re || we) begin
            illegal_s = align_err_s
                      | (!is_ram_s && !is_mmio_s)
                      | (is_mmio_s && (funct3 != F3_W));
        end else begin
            illegal_s = 1'b0;
        end
    end

    assign legal_rd_s = re & ~illegal_s;
    assign legal_wr_s = we & ~illegal_s;

    // MMIO read mux and source-word select for the lane logic.
    always_comb begin
        mmio_word_s = 32'h0000_0000;
        case (mmio_sel_s)
            REG_GPIO:     mmio_word_s = gpio_r;
            REG_CYCLE_LO: mmio_word_s = cycle_cnt_r[31:0];
            REG_CYCLE_HI: mmio_word_s = cycle_hi_snap_r;
            REG_FAULT:    mmio_word_s = fault_addr_r;
            default:      mmio_word_s = 32'h0000_0000;
        endcase
        if (is_mmio_s) begin
            src_word_s = mmio_word_s;
        end else begin
            src_word_s = ram_word_s;
        end
    end

    // Illegal or absent reads return zero so stale data never reaches rd.
    always_comb begin
        if (legal_rd_s) begin
            rdata = load_ext_s;
        end else begin
            rdata = 32'h0000_0000;
        end
    end

    assign misaligned = illegal_s;

    // RAM lane writes; deliberately not gated by rst so a store in the reset
    // cycle still lands.
    always_ff @(posedge clk) begin
        if (legal_wr_s && is_ram_s) begin
            for (int k = 0; k < 4; k++) begin
                if (byte_en_s[k]) begin
                    mem_r[word_idx_s][8*k +: 8] <= store_word_s[8*k +: 8];
                end
            end
        end
    end

    // MMIO registers, cycle counter and first-fault capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_cnt_r     <= 64'd0;
            cycle_hi_snap_r <= 32'h0000_0000;
            fault_addr_r    <= 32'h0000_0000;
            gpio_r          <= 32'h0000_0000;
            fault_r         <= 1'b0;
        end else begin
            cycle_cnt_r <= cycle_cnt_r + 64'd1;
            if (legal_rd_s && is_mmio_s && (mmio_sel_s == REG_CYCLE_LO)) begin
                cycle_hi_snap_r <= cycle_cnt_r[63:32];
            end
            if (legal_wr_s && is_mmio_s && (mmio_sel_s == REG_GPIO)) begin
                gpio_r <= wdata;
            end
            // An illegal clearing write counts as a fault, never as a clear.
            if (illegal_s) begin
                fault_r <= 1'b1;
                if (!fault_r) begin
                    fault_addr_r <= addr;
                end
            end else if (legal_wr_s && is_mmio_s && (mmio_sel_s == REG_FAULT)) begin
                fault_r      <= 1'b0;
                fault_addr_r <= 32'h0000_0000;
            end
        end
    end

    assign gpio_out = gpio_r;
    assign fault    = fault_r;

endmodule

// File: doc/ky32_dmem.md
# ky32_dmem

Data-memory responder for the kythera32 single-cycle core. It is the far end of the core's load/store interface: it takes the effective address, the store data and the write control, and returns load data in the same cycle. It decodes RV32I load/store widths, so it handles byte and halfword lanes, sign and zero extension, and misalignment. It also hosts a small memory-mapped register window: a GPIO output, a 64-bit cycle counter with an atomic high-word snapshot, and fault capture.

## Interface
Parameters:
- DEPTH_WORDS, 1024: RAM size in 32-bit words. Power of two. RAM occupies byte addresses 0 .. DEPTH_WORDS*4-1.
- MMIO_BASE, 32'hFFFF_0000: base address of the 16-byte register window.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- addr  in  32  byte address (core ALU output).
- wdata  in  32  store data, right-aligned (byte in [7:0], halfword in [15:0]).
- we  in  1  store strobe (core data-write control).
- re  in  1  load strobe.
- funct3  in  3  RV32I width code: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU.
- rdata  out  32  load result, combinational.
- misaligned  out  1  combinational; current access is illegal (misaligned, bad width, or unmapped).
- fault  out  1  sticky fault flag.
- gpio_out  out  32  GPIO register contents.

## Operation
- **Address decode**
  - RAM: addr < DEPTH_WORDS*4.
  - MMIO: addr[31:4] == MMIO_BASE[31:4].
  - Anything else is unmapped.
- **MMIO register map** (offsets from MMIO_BASE):
  - +0x0 GPIO: read/write.
  - +0x4 CYCLE_LO: read-only.
  - +0x8 CYCLE_HI_SNAP: read-only.
  - +0xC FAULT_ADDR: read-only. Any write to it clears fault and FAULT_ADDR.
- **Illegal access:** any of the following raises misaligned:
  - funct3 in {011, 110, 111};
  - SH/LH/LHU with addr[0]=1;
  - SW/LW with addr[1:0]≠0;
  - any MMIO access with funct3≠010;
  - an unmapped address.
  - Illegal writes are suppressed. Illegal reads return 0.
  - misaligned is evaluated only when re or we is high; otherwise it is 0.
- **Loads**
  - Select the lane using addr[1:0].
  - LB/LH sign-extend. LBU/LHU zero-extend.
  - rdata is 0 when re is 0.
- **Stores**
  - SB writes only lane addr[1:0] with wdata[7:0].
  - SH writes lanes {addr[1],0} and {addr[1],1} with wdata[15:0].
  - SW writes the full word.
  - Lanes not written are preserved.
- **Read and write in the same cycle** (we=1 and re=1): rdata shows the pre-edge contents; the write commits at the edge.
- **Cycle counter**
  - 64-bit counter, increments by 1 every cycle rst=0, wraps from 2^64-1 to 0.
  - A legal CYCLE_LO read (re=1) captures counter[63:32] into CYCLE_HI_SNAP at that edge, so a following CYCLE_HI_SNAP read matches the earlier LO read.
- **Fault capture**
  - On any illegal access, fault is set at the edge.
  - FAULT_ADDR captures addr only if fault was 0 (first fault wins).
  - If a clearing write is itself illegal, it still sets fault and does not clear.
- **Reset values:** gpio_out=0, fault=0, FAULT_ADDR=0, counter=0, CYCLE_HI_SNAP=0. RAM contents are not reset. rdata and misaligned are combinational, so they are 0 while re and we are low.
- **Reset mid-operation:** a store presented in the same cycle as rst=1 still commits to RAM. MMIO register writes are overridden by reset.

## Timing
- **Load latency:** 0 cycles. rdata is combinational from addr, funct3 and RAM.
- **Store latency:** committed at the rising edge. A load in the following cycle returns the new value.
- **Counter:** at the first edge with rst=0 the counter becomes 1. A CYCLE_LO read in cycle k after reset release returns k.
- **fault:** visible one cycle after the illegal access. misaligned is visible in the same cycle.
- **GPIO:** a write appears on gpio_out the cycle after the write.

## Structure
- **Shared package `ky32_pkg`** holds:
  - funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU);
  - MMIO offset constants (MMIO_GPIO, MMIO_CYCLE_LO, MMIO_CYCLE_HI, MMIO_FAULT);
  - the default MMIO_BASE.
- **Sub-module `ky32_lsu_align`** (combinational): holds lane select, sign/zero extension, byte-enable generation, store data replication and alignment check.
- **ky32_dmem** holds the RAM array, address decode and MMIO registers.

## Test plan
- **Byte/halfword stores and signed loads:**
  - SW 0x11223344 to 0x10, then SB 0xAA to 0x13; LW 0x10 returns 0xAA223344.
  - LB 0x13 returns 0xFFFFFFAA. LBU 0x13 returns 0x000000AA.
- **Halfword and misalignment:**
  - SH 0x8001 to 0x22; LH 0x22 returns 0xFFFF8001. LHU 0x22 returns 0x00008001.
  - LH 0x21 raises misaligned and returns 0; fault=1 next cycle with FAULT_ADDR=0x21.
  - A following SW to 0x25 is suppressed (target word unchanged) and FAULT_ADDR stays 0x21.
- **Fault clear:**
  - SW to MMIO_BASE+0xC clears fault and FAULT_ADDR.
  - SB to MMIO_BASE+0x0 raises misaligned and sets fault; gpio_out is unchanged.
- **Cycle counter:**
  - Release reset, idle 5 cycles; CYCLE_LO read in cycle 5 returns 5.
  - Force the counter to 0x00000000_FFFFFFFF (backdoor); a LO read returns 0xFFFFFFFF and the next HI_SNAP read returns 0, not 1.
- **Simultaneous read/write and reset:**
  - we=re=1 on 0x40 holding 0x0 with wdata 0x5: rdata=0 that cycle, 5 the next.
  - GPIO write 0xDEADBEEF with rst=1 leaves gpio_out=0.
- **Unmapped address:** LW to DEPTH_WORDS*4 raises misaligned and returns 0; fault is set.
